led_arbiter: RTL and testbench
==============================

# led_arbiter

Shares the board's two user LEDs between up to four requesters, such as debug monitors and status reporters, on the QM XC6SLX16 SDRAM board. Each requester asks to show a 2-bit pattern for a number of millisecond ticks. A round-robin, non-preemptive arbiter grants one request at a time and inserts a blank gap between displays. When no request is pending, a heartbeat blink drives the LEDs. The block sits between internal status logic and the top-level LED pins.

## Interface
- TICK_DIV, 50000: clock cycles per tick (1 ms at 50 MHz).
- HEARTBEAT_TICKS, 500: ticks between heartbeat toggles of LED[0].
- GAP_TICKS, 1: ticks of blank (LED = 00) after each display; must be at least 1.
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- req  input  4  request level; req[i] belongs to requester i.
- pat  input  8  pattern; requester i uses pat[2i+1:2i].
- dur  input  32  duration in ticks; requester i uses dur[8i+7:8i], unsigned.
- gnt  output  4  one-hot grant; high while requester i's pattern is displayed.
- done  output  4  one-cycle pulse on done[i] when requester i's display ends.
- LED  output  2  drives the board LED pins.

## Operation
- Free-running prescaler: hb_tick pulses once every TICK_DIV cycles from reset.
  - The heartbeat counter counts hb_tick pulses.
  - hb_led toggles every HEARTBEAT_TICKS ticks.
  - The heartbeat runs continuously in all states.
- State machine: IDLE, SHOW, GAP.
- IDLE:
  - LED = {1'b0, hb_led}.
  - If any req bit is high, select the first requester with req high, searching upward from (last + 1) mod 4 and wrapping.
  - In that cycle, latch pat[i] and dur[i], set gnt = one-hot(i), set last = i, and go to SHOW.
- SHOW:
  - LED = latched pattern.
  - A local cycle counter, cleared at grant, counts D × TICK_DIV cycles, where D = max(latched dur, 1). A dur of 0 is displayed for 1 tick.
  - On the final count, clear gnt, pulse done[i] for 1 cycle, and go to GAP.
- GAP:
  - LED = 00 for GAP_TICKS × TICK_DIV cycles, counted locally from GAP entry.
  - Then go to IDLE.
- Non-preemptive rules:
  - req, pat and dur are sampled only at grant.
  - Dropping req, or changing pat or dur, during SHOW has no effect.
  - Requesters must drop req after done. A still-high req is treated as a new request and competes in round-robin order.
- Fairness: a continuously requesting set is served in rotation. No requester waits more than 3 displays.
- Reset values:
  - State IDLE, LED = 00, gnt = 0000, done = 0000.
  - last = 3, so requester 0 has first priority.
  - All counters = 0, hb_led = 0.
  - Reset asserted mid-SHOW or mid-GAP aborts the display immediately and emits no done pulse.

## Timing
- Grant latency: req rising before edge k (in IDLE) gives gnt, and LED = pattern, after edge k. Registered, so 1 cycle.
- gnt stays high for exactly D × TICK_DIV cycles.
- done[i] is high for exactly 1 cycle, starting on the same edge that clears gnt[i]. That edge also sets LED = 00.
- The GAP lasts exactly GAP_TICKS × TICK_DIV cycles. The first IDLE cycle follows it.
  - A request pending in that first IDLE cycle is granted on the next edge.
  - The minimum grant-to-grant spacing is therefore (D + GAP_TICKS) × TICK_DIV + 1 cycles.
- The heartbeat phase is independent of arbitration. LED[0] shows hb_led only while in IDLE.
- All outputs are registered; there is no combinational path from req, pat or dur to outputs.

## Test plan
Bench parameters: TICK_DIV = 4, HEARTBEAT_TICKS = 3, GAP_TICKS = 1.
- Reset, then idle for 60 cycles with no requests.
  - Required: LED = 00 and gnt = 0 during reset.
  - After release, LED[0] toggles every 12 cycles, LED[1] = 0, and done stays 0.
- req = 0001, pat[1:0] = 11, dur[7:0] = 2.
  - Required: gnt = 0001 one cycle later and LED = 11 for exactly 8 cycles.
  - Then done[0] pulses for 1 cycle, LED = 00 for 4 cycles, then the heartbeat resumes.
- req = 1111 held high, every dur = 1.
  - Required: grants in order 0, 1, 2, 3, 0.
  - Each grant lasts 4 cycles, and successive grant starts are 9 cycles apart.
- req[2] drops 1 cycle after its grant, with dur = 3.
  - Required: the display still lasts 12 cycles and done[2] still pulses.
- dur = 0 for requester 1.
  - Required: gnt[1] is high for 4 cycles (treated as 1 tick).
- RST asserted 5 cycles into a dur = 4 display.
  - Required: LED = 00 and gnt = 0 asynchronously, with no done pulse.
  - After release, requester 0 wins against simultaneous req = 1001.

Source files
------------

// File: rtl/led_arbiter.sv
// Round-robin, non-preemptive sharing of the two board LEDs between four requesters,
// with a blank gap after each display and a heartbeat blink when idle.
module led_arbiter #(
  parameter int unsigned TICK_DIV        = 50000,
  parameter int unsigned HEARTBEAT_TICKS = 500,
  parameter int unsigned GAP_TICKS       = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  req,
  input  logic [7:0]  pat,
  input  logic [31:0] dur,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic [1:0]  LED
);

  localparam int unsigned CW = 32;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = (HEARTBEAT_TICKS > 1) ? $clog2(HEARTBEAT_TICKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_e;

  state_e          state_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [HW-1:0]   hb_cnt_q, hb_cnt_d;
  logic            hb_led_q, hb_led_d;
  logic            hb_tick, hb_wrap;
  logic [CW-1:0]   cnt_q, lim_q;
  logic [1:0]      pat_q, led_q;
  logic [1:0]      last_q;
  logic [3:0]      gnt_q, done_q;
  logic [1:0]      sel_idx;
  logic [1:0]      sel_pat;
  logic [7:0]      sel_raw;
  logic [CW-1:0]   sel_lim;

  // First requester with req high, searching upward from last+1 and wrapping.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (r[idx] && !found) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Free-running tick prescaler and heartbeat toggle.
  always_comb begin
    hb_tick  = (presc_q == PW'(TICK_DIV - 1));
    hb_wrap  = hb_tick && (hb_cnt_q == HW'(HEARTBEAT_TICKS - 1));
    presc_d  = hb_tick ? '0 : presc_q + PW'(1);
    hb_cnt_d = hb_cnt_q;
    if (hb_tick) hb_cnt_d = hb_wrap ? '0 : hb_cnt_q + HW'(1);
    hb_led_d = hb_wrap ? ~hb_led_q : hb_led_q;
  end

  // Grant candidate; a zero duration is shown for one tick.
  always_comb begin
    sel_idx = rr_pick(last_q, req);
    sel_pat = pat[{sel_idx, 1'b0} +: 2];
    sel_raw = dur[{sel_idx, 3'b000} +: 8];
    sel_lim = CW'((sel_raw == 8'd0) ? 8'd1 : sel_raw) * CW'(TICK_DIV) - CW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      hb_cnt_q <= '0;
      hb_led_q <= 1'b0;
      cnt_q    <= '0;
      lim_q    <= '0;
      pat_q    <= 2'b00;
      led_q    <= 2'b00;
      last_q   <= 2'd3;
      gnt_q    <= 4'b0000;
      done_q   <= 4'b0000;
    end else begin
      presc_q  <= presc_d;
      hb_cnt_q <= hb_cnt_d;
      hb_led_q <= hb_led_d;
      done_q   <= 4'b0000;
      case (state_q)
        S_IDLE: begin
          led_q <= {1'b0, hb_led_d};
          if (|req) begin
            gnt_q   <= 4'b0001 << sel_idx;
            pat_q   <= sel_pat;
            led_q   <= sel_pat;
            lim_q   <= sel_lim;
            last_q  <= sel_idx;
            cnt_q   <= '0;
            state_q <= S_SHOW;
          end
        end
        S_SHOW: begin
          led_q <= pat_q;
          if (cnt_q == lim_q) begin
            gnt_q   <= 4'b0000;
            done_q  <= gnt_q;
            led_q   <= 2'b00;
            cnt_q   <= '0;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_GAP: begin
          led_q <= 2'b00;
          if (cnt_q == CW'(GAP_TICKS * TICK_DIV - 1)) begin
            led_q   <= {1'b0, hb_led_d};
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= 4'b0000;
          led_q   <= 2'b00;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign LED  = led_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter: expected displays are queued at stimulus time and
// expanded into a per-cycle {gnt, LED, done} expectation against a heartbeat model.
module tb_led_arbiter;

  localparam int unsigned TD = 4;
  localparam int unsigned HB = 3;
  localparam int unsigned GT = 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [7:0]  pat = 8'h00;
  logic [31:0] dur = 32'h0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [1:0]  LED;

  led_arbiter #(.TICK_DIV(TD), .HEARTBEAT_TICKS(HB), .GAP_TICKS(GT)) dut (
    .CLK(CLK), .RST(RST), .req(req), .pat(pat), .dur(dur),
    .gnt(gnt), .done(done), .LED(LED)
  );

  always #5 CLK = ~CLK;

  // Edges since reset release, for the heartbeat model.
  int ecnt;
  always @(posedge CLK or posedge RST) begin
    if (RST) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  typedef struct {
    logic [3:0] g;
    logic [1:0] p;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [9:0] olog[256];
  logic [9:0] ev[256];
  int         logn;
  int         vectors     = 0;
  int         miscompares = 0;

  // Record n cycles of outputs; the default expectation is idle with heartbeat on LED[0].
  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      olog[logn] = {gnt, LED, done};
      ev[logn]   = {4'b0000, 1'b0, 1'((ecnt / int'(TD * HB)) % 2), 4'b0000};
      logn++;
    end
  endtask

  // Expand the next queued display, granted at index s, into per-cycle expectations.
  task automatic fill(input int s);
    exp_t e;
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    for (int k = 0; k < e.cyc; k++) ev[s + k] = {e.g, e.p, 4'b0000};
    ev[s + e.cyc] = {4'b0000, 2'b00, e.g};
    for (int k = 1; k < int'(GT * TD); k++) ev[s + e.cyc + k] = 10'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req = 4'b0000;
    repeat (2) @(posedge CLK);
    #1;
    RST  = 1'b0;
    logn = 0;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(posedge CLK);
      #1;
      vectors++;
      if ({gnt, LED, done} !== 10'b0) begin
        miscompares++;
        $display("FAIL reset_hold got {gnt,LED,done}=%b want=%b", {gnt, LED, done}, 10'b0);
      end
    end
    RST  = 1'b0;
    logn = 0;
    observe(60);
    for (int k = 0; k < 60; k++) begin
      vectors++;
      if (olog[k] !== ev[k]) begin
        miscompares++;
        $display("FAIL heartbeat cyc=%0d got {gnt,LED,done}=%b want=%b", k, olog[k], ev[k]);
      end
    end
  endtask

  task automatic test_single();
    logn = 0;
    req = 4'b0001; pat = 8'b0000_0011; dur = 32'd2;
    sbq.push_back('{g: 4'b0001, p: 2'b11, cyc: 8});
    observe(1);
    req = 4'b0000;
    observe(15);
    fill(0);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (olog[k] !== ev[k]) begin
        miscompares++;
        $display("FAIL single cyc=%0d got {gnt,LED,done}=%b want=%b", k, olog[k], ev[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 4'b1111; pat = 8'b00_01_10_11; dur = 32'h01010101;
    sbq.push_back('{g: 4'b0001, p: 2'b11, cyc: 4});
    sbq.push_back('{g: 4'b0010, p: 2'b10, cyc: 4});
    sbq.push_back('{g: 4'b0100, p: 2'b01, cyc: 4});
    sbq.push_back('{g: 4'b1000, p: 2'b00, cyc: 4});
    sbq.push_back('{g: 4'b0001, p: 2'b11, cyc: 4});
    observe(41);
    req = 4'b0000;
    observe(8);
    for (int n = 0; n < 5; n++) fill(9 * n);
    for (int k = 0; k < 49; k++) begin
      vectors++;
      if (olog[k] !== ev[k]) begin
        miscompares++;
        $display("FAIL round_robin cyc=%0d got {gnt,LED,done}=%b want=%b", k, olog[k], ev[k]);
      end
    end
  endtask

  task automatic test_drop_mid_show();
    do_reset();
    req = 4'b0100; pat = 8'b00_10_00_00; dur = 32'h00030000;
    sbq.push_back('{g: 4'b0100, p: 2'b10, cyc: 12});
    observe(2);
    req = 4'b0000; pat = 8'hFF; dur = 32'hFFFFFFFF;
    observe(18);
    fill(0);
    for (int k = 0; k < 20; k++) begin
      vectors++;
      if (olog[k] !== ev[k]) begin
        miscompares++;
        $display("FAIL drop_mid_show cyc=%0d got {gnt,LED,done}=%b want=%b", k, olog[k], ev[k]);
      end
    end
  endtask

  task automatic test_dur_zero();
    do_reset();
    req = 4'b0010; pat = 8'b00_00_01_00; dur = 32'h0;
    sbq.push_back('{g: 4'b0010, p: 2'b01, cyc: 4});
    observe(1);
    req = 4'b0000;
    observe(9);
    fill(0);
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (olog[k] !== ev[k]) begin
        miscompares++;
        $display("FAIL dur_zero cyc=%0d got {gnt,LED,done}=%b want=%b", k, olog[k], ev[k]);
      end
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    req = 4'b0001; pat = 8'b0000_0011; dur = 32'd4;
    sbq.push_back('{g: 4'b0001, p: 2'b11, cyc: 16});
    observe(1);
    req = 4'b0000;
    observe(4);
    fill(0);
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (olog[k] !== ev[k]) begin
        miscompares++;
        $display("FAIL abort_pre cyc=%0d got {gnt,LED,done}=%b want=%b", k, olog[k], ev[k]);
      end
    end
    RST = 1'b1;
    #1;
    vectors++;
    if ({gnt, LED, done} !== 10'b0) begin
      miscompares++;
      $display("FAIL abort_async got {gnt,LED,done}=%b want=%b", {gnt, LED, done}, 10'b0);
    end
    repeat (2) begin
      @(posedge CLK);
      #1;
      vectors++;
      if ({gnt, LED, done} !== 10'b0) begin
        miscompares++;
        $display("FAIL abort_hold got {gnt,LED,done}=%b want=%b", {gnt, LED, done}, 10'b0);
      end
    end
    RST  = 1'b0;
    logn = 0;
    req = 4'b1001; pat = 8'b01_00_00_10; dur = 32'h02000001;
    sbq.push_back('{g: 4'b0001, p: 2'b10, cyc: 4});
    observe(1);
    req = 4'b0000;
    observe(8);
    fill(0);
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (olog[k] !== ev[k]) begin
        miscompares++;
        $display("FAIL abort_regrant cyc=%0d got {gnt,LED,done}=%b want=%b", k, olog[k], ev[k]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got t=%0t want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop_mid_show();
    test_dur_zero();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
